// File: rtl/dc_timing_monitor.sv
// Dreamcast raw _hsync/_vsync timing monitor: measures line and frame timing and
// classifies the signal as 240p, 480i or 480p with frame-count glitch filtering and timeout.
module dc_timing_monitor #(
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned TIMEOUT       = 5_400_000,
  parameter int unsigned H31K_MIN      = 1600,
  parameter int unsigned H31K_MAX      = 1850,
  parameter int unsigned H15K_MIN      = 3300,
  parameter int unsigned H15K_MAX      = 3550
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        _hsync,
  input  logic        _vsync,
  output logic [11:0] line_period,
  output logic [9:0]  frame_lines,
  output logic [1:0]  mode,
  output logic        interlaced,
  output logic        locked,
  output logic        mode_changed,
  output logic        no_signal
);

  localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] StabMax    = SW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT);
  localparam logic [TW-1:0] TimeoutHit = TW'(TIMEOUT - 1);
  localparam logic [11:0]   H31Lo      = 12'(H31K_MIN);
  localparam logic [11:0]   H31Hi      = 12'(H31K_MAX);
  localparam logic [11:0]   H15Lo      = 12'(H15K_MIN);
  localparam logic [11:0]   H15Hi      = 12'(H15K_MAX);

  localparam logic [1:0] ModeUnknown = 2'd0;
  localparam logic [1:0] Mode240p    = 2'd1;
  localparam logic [1:0] Mode480i    = 2'd2;
  localparam logic [1:0] Mode480p    = 2'd3;

  typedef enum logic [1:0] {StSearch, StLocked, StLost} state_e;
  state_e state_q, state_d;

  logic          hs_meta, hs_sync, hs_prev, vs_meta, vs_sync, vs_prev;
  logic          hs_fall, vs_fall, timeout_hit, in31, in15, inter_new;
  logic [11:0]   hcnt_q, hcnt_d, vs_phase_q, vs_phase_d, line_period_d, phase_diff;
  logic [9:0]    vcnt_q, vcnt_d, frame_lines_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    prev_cand_q, prev_cand_d, cand, mode_d;
  logic          interlaced_d, locked_d, no_signal_d;

  assign hs_fall     = hs_prev & ~hs_sync;
  assign vs_fall     = vs_prev & ~vs_sync;
  assign timeout_hit = ~vs_fall && (tcnt_q == TimeoutHit);

  // Classification of the frame that ends at this vs_fall.
  always_comb begin
    phase_diff = (hcnt_q >= vs_phase_q) ? hcnt_q - vs_phase_q : vs_phase_q - hcnt_q;
    inter_new  = phase_diff > {2'b00, line_period[11:2]};
    in31       = (line_period >= H31Lo) && (line_period <= H31Hi);
    in15       = (line_period >= H15Lo) && (line_period <= H15Hi);
    cand       = ModeUnknown;
    if (in31 && vcnt_q >= 10'd520 && vcnt_q <= 10'd530) begin
      cand = Mode480p;
    end else if (in15 && vcnt_q >= 10'd261 && vcnt_q <= 10'd264) begin
      cand = inter_new ? Mode480i : Mode240p;
    end
  end

  always_comb begin
    hcnt_d        = hcnt_q;
    line_period_d = line_period;
    vcnt_d        = vcnt_q;
    frame_lines_d = frame_lines;
    vs_phase_d    = vs_phase_q;
    interlaced_d  = interlaced;
    prev_cand_d   = prev_cand_q;
    stab_d        = stab_q;
    tcnt_d        = tcnt_q;
    state_d       = state_q;
    mode_d        = mode;
    locked_d      = locked;
    no_signal_d   = no_signal;

    if (hs_fall) begin
      line_period_d = hcnt_q;
      hcnt_d        = 12'd1;
    end else if (hcnt_q != 12'hfff) begin
      hcnt_d = hcnt_q + 12'd1;
    end

    if (vs_fall) begin
      // A coincident hsync fall is the first line of the new frame.
      vcnt_d        = hs_fall ? 10'd1 : 10'd0;
      frame_lines_d = vcnt_q;
      vs_phase_d    = hcnt_q;
      interlaced_d  = inter_new;
      prev_cand_d   = cand;
      if (cand != prev_cand_q) begin
        stab_d = SW'(1);
      end else if (stab_q != StabMax) begin
        stab_d = stab_q + SW'(1);
      end
    end else if (hs_fall && vcnt_q != 10'h3ff) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    if (vs_fall) begin
      tcnt_d = '0;
    end else if (tcnt_q != TimeoutMax) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    if (timeout_hit) begin
      state_d      = StLost;
      no_signal_d  = 1'b1;
      locked_d     = 1'b0;
      mode_d       = ModeUnknown;
      stab_d       = '0;
      interlaced_d = 1'b0;
    end else if (vs_fall) begin
      unique case (state_q)
        StSearch: begin
          if (stab_d == StabMax && cand != ModeUnknown) begin
            mode_d   = cand;
            locked_d = 1'b1;
            state_d  = StLocked;
          end
        end
        StLocked: begin
          if (cand != mode) begin
            locked_d = 1'b0;
            state_d  = StSearch;
          end
        end
        StLost: begin
          no_signal_d = 1'b0;
          stab_d      = SW'(1);
          state_d     = StSearch;
        end
        default: state_d = StLost;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hs_meta      <= 1'b1;
      hs_sync      <= 1'b1;
      hs_prev      <= 1'b1;
      vs_meta      <= 1'b1;
      vs_sync      <= 1'b1;
      vs_prev      <= 1'b1;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vs_phase_q   <= '0;
      prev_cand_q  <= ModeUnknown;
      stab_q       <= '0;
      tcnt_q       <= '0;
      state_q      <= StLost;
      line_period  <= '0;
      frame_lines  <= '0;
      mode         <= ModeUnknown;
      interlaced   <= 1'b0;
      locked       <= 1'b0;
      mode_changed <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      hs_meta      <= _hsync;
      hs_sync      <= hs_meta;
      hs_prev      <= hs_sync;
      vs_meta      <= _vsync;
      vs_sync      <= vs_meta;
      vs_prev      <= vs_sync;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vs_phase_q   <= vs_phase_d;
      prev_cand_q  <= prev_cand_d;
      stab_q       <= stab_d;
      tcnt_q       <= tcnt_d;
      state_q      <= state_d;
      line_period  <= line_period_d;
      frame_lines  <= frame_lines_d;
      mode         <= mode_d;
      interlaced   <= interlaced_d;
      locked       <= locked_d;
      mode_changed <= (mode_d != mode);
      no_signal    <= no_signal_d;
    end
  end

endmodule

// File: tb/tb_dc_timing_monitor.sv
// Directed bench for dc_timing_monitor with shrunken line-period windows so whole frames stay short;
// a second instance with TIMEOUT = 1000 covers the no-signal path.
module tb_dc_timing_monitor;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [11:0] line_period, line_period_t;
  logic [9:0]  frame_lines, frame_lines_t;
  logic [1:0]  mode, mode_t;
  logic        interlaced, interlaced_t, locked, locked_t;
  logic        mode_changed, mode_changed_t, no_signal, no_signal_t;

  int checks = 0;
  int fails = 0;
  int hper = 2;
  int hpos = 0;
  int mc_cnt = 0;
  int mc_cnt_t = 0;
  int mc0, mct0;

  // 31 kHz lines are 2 clocks, 15 kHz lines are 3 clocks.
  dc_timing_monitor #(
    .STABLE_FRAMES(4), .TIMEOUT(2000),
    .H31K_MIN(2), .H31K_MAX(2), .H15K_MIN(3), .H15K_MAX(4)
  ) dut (
    .clock(clock), .nreset(nreset), ._hsync(hs), ._vsync(vs),
    .line_period(line_period), .frame_lines(frame_lines), .mode(mode),
    .interlaced(interlaced), .locked(locked), .mode_changed(mode_changed),
    .no_signal(no_signal)
  );

  dc_timing_monitor #(
    .STABLE_FRAMES(4), .TIMEOUT(1000),
    .H31K_MIN(2), .H31K_MAX(2), .H15K_MIN(3), .H15K_MAX(4)
  ) dut_t (
    .clock(clock), .nreset(nreset), ._hsync(hs), ._vsync(vs),
    .line_period(line_period_t), .frame_lines(frame_lines_t), .mode(mode_t),
    .interlaced(interlaced_t), .locked(locked_t), .mode_changed(mode_changed_t),
    .no_signal(no_signal_t)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mode_changed)   mc_cnt   <= mc_cnt + 1;
    if (mode_changed_t) mc_cnt_t <= mc_cnt_t + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs len clocks of continuous hsync; a vsync pulse starts at index 0 when vfall is set.
  task automatic run(input int len, input bit vfall);
    for (int i = 0; i < len; i++) begin
      hs = (hpos == 0) ? 1'b0 : 1'b1;
      vs = (vfall && i < 4) ? 1'b0 : 1'b1;
      hpos = (hpos + 1) % hper;
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input int newper);
    nreset = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    hper = newper;
    hpos = 0;
    repeat (4) @(negedge clock);
    nreset = 1'b1;
  endtask

  initial begin
    do_reset(2);
    chk("rst_line_period", 32'(line_period), 0);
    chk("rst_frame_lines", 32'(frame_lines), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_interlaced", 32'(interlaced), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_mode_changed", 32'(mode_changed), 0);
    chk("rst_no_signal", 32'(no_signal), 1);
    chk("rst_no_signal_t", 32'(no_signal_t), 1);

    // 480p: 525 lines of 2 clocks.
    run(8, 1'b0);
    repeat (4) run(1050, 1'b1);
    chk("p_line_period", 32'(line_period), 2);
    chk("p_frame_lines", 32'(frame_lines), 525);
    chk("p_locked_pre", 32'(locked), 0);
    chk("p_no_signal", 32'(no_signal), 0);
    run(6, 1'b1);
    chk("p_locked", 32'(locked), 1);
    chk("p_mode", 32'(mode), 3);
    chk("p_interlaced", 32'(interlaced), 0);
    chk("p_mc_count", mc_cnt, 1);
    run(1044, 1'b0);

    // One 400-line glitch frame, then 480p again.
    run(800, 1'b1);
    run(6, 1'b1);
    chk("g_locked_drop", 32'(locked), 0);
    chk("g_mode_hold", 32'(mode), 3);
    chk("g_frame_lines", 32'(frame_lines), 400);
    chk("g_mc_count", mc_cnt, 1);
    run(1044, 1'b0);
    repeat (3) run(1050, 1'b1);
    chk("g_locked_pre", 32'(locked), 0);
    run(6, 1'b1);
    chk("g_relock", 32'(locked), 1);
    chk("g_relock_mode", 32'(mode), 3);
    chk("g_relock_mc", mc_cnt, 1);
    run(1044, 1'b0);

    // 240p: 262 lines of 3 clocks, constant vsync phase.
    do_reset(3);
    mc0 = mc_cnt;
    run(12, 1'b0);
    repeat (4) run(786, 1'b1);
    chk("s_locked_pre", 32'(locked), 0);
    chk("s_line_period", 32'(line_period), 3);
    chk("s_frame_lines", 32'(frame_lines), 262);
    run(6, 1'b1);
    chk("s_locked", 32'(locked), 1);
    chk("s_mode", 32'(mode), 1);
    chk("s_interlaced", 32'(interlaced), 0);
    chk("s_mc_count", mc_cnt - mc0, 1);
    chk("s_locked_t", 32'(locked_t), 1);
    chk("s_mode_t", 32'(mode_t), 1);
    run(780, 1'b0);

    // vsync stops: the TIMEOUT = 1000 instance drops to no-signal.
    mct0 = mc_cnt_t;
    run(1000, 1'b1);
    chk("t_no_signal_pre", 32'(no_signal_t), 0);
    chk("t_mode_pre", 32'(mode_t), 1);
    chk("t_locked_pre", 32'(locked_t), 1);
    run(5, 1'b0);
    chk("t_no_signal", 32'(no_signal_t), 1);
    chk("t_mode", 32'(mode_t), 0);
    chk("t_locked", 32'(locked_t), 0);
    chk("t_interlaced", 32'(interlaced_t), 0);
    chk("t_mc_count", mc_cnt_t - mct0, 1);
    chk("t_main_no_signal", 32'(no_signal), 0);
    run(6, 1'b1);
    chk("t_no_signal_clear", 32'(no_signal_t), 0);

    // 480i: fields of 263/262 lines, vsync alternating between line start and one clock in.
    do_reset(3);
    mc0 = mc_cnt;
    run(12, 1'b0);
    run(787, 1'b1);
    run(788, 1'b1);
    run(787, 1'b1);
    run(788, 1'b1);
    chk("i_locked_pre", 32'(locked), 0);
    chk("i_interlaced_pre", 32'(interlaced), 1);
    chk("i_frame_lines_a", 32'(frame_lines), 263);
    run(6, 1'b1);
    chk("i_locked", 32'(locked), 1);
    chk("i_mode", 32'(mode), 2);
    chk("i_interlaced", 32'(interlaced), 1);
    chk("i_frame_lines_b", 32'(frame_lines), 262);
    chk("i_mc_count", mc_cnt - mc0, 1);
    run(781, 1'b0);

    // Asynchronous reset mid-field while locked.
    run(300, 1'b1);
    #1 nreset = 1'b0;
    #1;
    chk("r_locked", 32'(locked), 0);
    chk("r_mode", 32'(mode), 0);
    chk("r_no_signal", 32'(no_signal), 1);
    chk("r_line_period", 32'(line_period), 0);
    chk("r_frame_lines", 32'(frame_lines), 0);
    chk("r_interlaced", 32'(interlaced), 0);
    chk("r_mode_changed", 32'(mode_changed), 0);
    run(5, 1'b0);
    nreset = 1'b1;
    run((hper - hpos) % hper, 1'b0);
    run(12, 1'b0);
    mc0 = mc_cnt;
    run(787, 1'b1);
    run(788, 1'b1);
    run(787, 1'b1);
    run(788, 1'b1);
    chk("r_locked_pre", 32'(locked), 0);
    run(6, 1'b1);
    chk("r_relock", 32'(locked), 1);
    chk("r_relock_mode", 32'(mode), 2);
    chk("r_relock_mc", mc_cnt - mc0, 1);
    chk("r_relock_no_signal", 32'(no_signal), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
